char_line_buffer: RTL

CHAR_LINE_BUFFER -- requirements
Module: char_line_buffer

---
 rtl/char_pkg.sv | 17 +
 rtl/char_line_buffer_if.sv | 12 +
 rtl/scancode_filter.sv | 50 +++++
 rtl/char_line_buffer.sv | 92 +++++++++
 4 files changed

// File: rtl/char_pkg.sv
// Shared constants and FSM encoding for the PS/2 character line buffer.
// Holds the break/extended prefix bytes, default edit codes and decode states.
// Used by: scancode_filter, char_line_buffer.
package char_pkg;

   localparam logic [7:0] BRK_PREFIX      = 8'hF0;  // break (key release) prefix
   localparam logic [7:0] EXT_PREFIX      = 8'hE0;  // extended key prefix
   localparam logic [7:0] DEF_BKSP_CODE   = 8'h66;  // backspace make code
   localparam logic [7:0] DEF_ENTER_CODE  = 8'h5A;  // enter make code

   typedef enum logic [1:0] {
      ST_NORM = 2'd0,  // next byte is a make code or a prefix
      ST_BRK  = 2'd1,  // next byte is the released key, discard it
      ST_EXT  = 2'd2   // extended prefix seen, waiting for break or key
   } filt_state_t;

endpackage

// File: rtl/char_line_buffer_if.sv
// PS/2 byte stream bundle: one strobe plus the received byte.
// master drives the byte, slave samples it when ps2_enable is high.
// No backpressure: every strobed byte is consumed in the cycle it arrives.
interface char_line_buffer_if #(
   parameter int CODE_W = 8
);
   logic              ps2_enable;
   logic [CODE_W-1:0] ps2_info;

   modport master (output ps2_enable, ps2_info);
   modport slave  (input  ps2_enable, ps2_info);
endinterface

// File: rtl/scancode_filter.sv
// Strips break sequences and extended prefixes from a PS/2 byte stream.
// Latency: make_valid/make_code are combinational on the strobed byte so the
// caller can register them on the same edge; no backpressure, one byte/cycle.
// Ports: clock, reset (async active-low), ps2 (byte stream), make_valid, make_code.
module scancode_filter
   import char_pkg::*;
#(
   parameter int CODE_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   char_line_buffer_if.slave  ps2,
   output logic               make_valid,
   output logic [CODE_W-1:0]  make_code
);

   localparam logic [CODE_W-1:0] BRK_BYTE = CODE_W'(BRK_PREFIX);
   localparam logic [CODE_W-1:0] EXT_BYTE = CODE_W'(EXT_PREFIX);

   filt_state_t state;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_NORM;
      end else if (ps2.ps2_enable) begin
         case (state)
            ST_NORM: begin
               if (ps2.ps2_info == BRK_BYTE)      state <= ST_BRK;
               else if (ps2.ps2_info == EXT_BYTE) state <= ST_EXT;
               else                               state <= ST_NORM;
            end
            ST_BRK:  state <= ST_NORM;  // released key code is dropped
            ST_EXT: begin
               // E0 F0 xx is an extended release; E0 xx is an extended make
               // that this buffer does not store.
               if (ps2.ps2_info == BRK_BYTE) state <= ST_BRK;
               else                          state <= ST_NORM;
            end
            default: state <= ST_NORM;
         endcase
      end
   end

   // Decoded from the registered state and the live byte so the make code
   // lands in the line buffer on the same edge that samples it.
   assign make_valid = ps2.ps2_enable && (state == ST_NORM) &&
                       (ps2.ps2_info != BRK_BYTE) && (ps2.ps2_info != EXT_BYTE);
   assign make_code  = ps2.ps2_info;

endmodule

// File: rtl/char_line_buffer.sv
// Collects PS/2 make codes into a shift buffer with backspace and enter commit.
// Latency: 1 cycle, every output registered on the edge that samples the byte.
// No backpressure: one byte per cycle; chars arriving while full are dropped
// and flagged through the sticky overflow bit.
// Ports: clock, reset (async active-low), ps2_enable/ps2_info (byte in),
//        out/count/full (live buffer), line_out/line_valid (commit), overflow.
module char_line_buffer
   import char_pkg::*;
#(
   parameter int                CHARS      = 4,
   parameter int                CODE_W     = 8,
   parameter logic [CODE_W-1:0] BKSP_CODE  = CODE_W'(DEF_BKSP_CODE),
   parameter logic [CODE_W-1:0] ENTER_CODE = CODE_W'(DEF_ENTER_CODE)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         ps2_enable,
   input  logic [CODE_W-1:0]            ps2_info,
   output logic [CHARS*CODE_W-1:0]      out,
   output logic [$clog2(CHARS+1)-1:0]   count,
   output logic                         full,
   output logic [CHARS*CODE_W-1:0]      line_out,
   output logic                         line_valid,
   output logic                         overflow
);

   localparam int BUF_W = CHARS * CODE_W;
   localparam int CNT_W = $clog2(CHARS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHARS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   char_line_buffer_if #(.CODE_W(CODE_W)) byte_bus ();

   assign byte_bus.ps2_enable = ps2_enable;
   assign byte_bus.ps2_info   = ps2_info;

   logic              make_valid;
   logic [CODE_W-1:0] make_code;

   scancode_filter #(.CODE_W(CODE_W)) u_filter (
      .clock      (clock),
      .reset      (reset),
      .ps2        (byte_bus.slave),
      .make_valid (make_valid),
      .make_code  (make_code)
   );

   // Newest char enters at the LSB slot. Truncating the concatenation drops
   // the oldest slot and stays legal when CHARS is 1.
   logic [BUF_W-1:0] out_push;
   logic [CNT_W-1:0] count_inc;

   assign out_push  = BUF_W'({out, make_code});
   assign count_inc = count + CNT_ONE;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out        <= '0;
         count      <= '0;
         full       <= 1'b0;
         line_out   <= '0;
         line_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         line_valid <= 1'b0;
         if (make_valid) begin
            if (make_code == ENTER_CODE) begin
               // Empty lines still commit so the consumer sees every enter.
               line_out   <= out;
               line_valid <= 1'b1;
               out        <= '0;
               count      <= '0;
               full       <= 1'b0;
               overflow   <= 1'b0;
            end else if (make_code == BKSP_CODE) begin
               if (count != '0) begin
                  out   <= out >> CODE_W;
                  count <= count - CNT_ONE;
                  full  <= 1'b0;
               end
            end else if (!full) begin
               out   <= out_push;
               count <= count_inc;
               full  <= (count_inc == CNT_MAX);
            end else begin
               overflow <= 1'b1;
            end
         end
      end
   end

endmodule
